// File: rtl/noc_rr_port_if.sv
// Request/response and RAM-side signal bundle for noc_rr_port.
// slave is the arbiter side; master is the requester/RAM side.
interface noc_rr_port_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4
);

  logic [NUM_WR-1:0]            wr_valid;
  logic [NUM_WR-1:0]            wr_ready;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;

  logic [NUM_RD-1:0]            rd_valid;
  logic [NUM_RD-1:0]            rd_ready;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_rvalid;
  logic [DATA_WIDTH-1:0]        rd_rdata;

  logic                         ram_ena;
  logic                         ram_write;
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic [DATA_WIDTH-1:0]        ram_din;
  logic [DATA_WIDTH-1:0]        ram_dout;

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready,
    input  rd_valid,
    input  rd_addr,
    output rd_ready,
    output rd_rvalid,
    output rd_rdata,
    output ram_ena,
    output ram_write,
    output ram_addr,
    output ram_din,
    input  ram_dout
  );

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready,
    output rd_valid,
    output rd_addr,
    input  rd_ready,
    input  rd_rvalid,
    input  rd_rdata,
    input  ram_ena,
    input  ram_write,
    input  ram_addr,
    input  ram_din,
    output ram_dout
  );

endinterface

// File: rtl/noc_rr_port.sv
// Round-robin arbiter sharing one single-port RAM between
// NUM_WR write ports and NUM_RD read ports.
module noc_rr_port #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int NUM_WR      = 2,
  parameter int NUM_RD      = 4,
  parameter int RAM_LATENCY = 1,
  parameter int PRIO_MODE   = 0
) (
  input logic          clk,
  input logic          rst,
  noc_rr_port_if.slave bus
);

  localparam int N  = NUM_WR + NUM_RD;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int D  = RAM_LATENCY + 1;

  logic [PW-1:0]         ptr_a;
  logic [PW-1:0]         ptr_b;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_wr;
  logic [N-1:0]          gnt_vec;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IW-1:0]         rd_id;
  logic [D-1:0]          pv;
  logic [IW-1:0]         pid [D];

  // First requester at or above p, wrapping within a ring of n.
  function automatic logic [PW:0] rr_pick(
    input logic [N-1:0]  r,
    input logic [PW-1:0] p,
    input int            n
  );
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(p) + k;
        if (j >= n) j = j - n;
        if (r[j[PW-1:0]]) res = {1'b1, j[PW-1:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] rr_next(
    input logic [PW-1:0] g,
    input int            n
  );
    return (int'(g) == n - 1) ? '0 : g + 1'b1;
  endfunction

  // Pick the winner: one ring, or writes ahead of reads.
  always_comb begin
    logic [PW:0] pick;
    pick    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (PRIO_MODE == 0) begin
      pick    = rr_pick({bus.rd_valid, bus.wr_valid}, ptr_a, N);
      gnt_vld = pick[PW];
      gnt_idx = pick[PW-1:0];
    end else if (|bus.wr_valid) begin
      pick    = rr_pick(N'(bus.wr_valid), ptr_a, NUM_WR);
      gnt_vld = pick[PW];
      gnt_idx = pick[PW-1:0];
    end else begin
      pick    = rr_pick(N'(bus.rd_valid), ptr_b, NUM_RD);
      gnt_vld = pick[PW];
      gnt_idx = pick[PW-1:0] + PW'(NUM_WR);
    end
    if (!rst) gnt_vld = 1'b0;
    gnt_vec = gnt_vld ? (N'(1) << gnt_idx) : '0;
    gnt_wr  = |gnt_vec[NUM_WR-1:0];
  end

  assign bus.wr_ready = gnt_vec[NUM_WR-1:0];
  assign bus.rd_ready = gnt_vec[N-1:NUM_WR];

  // Route the granted port's address, data and read id.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    rd_id    = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (gnt_vec[i]) begin
        sel_addr = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (gnt_vec[NUM_WR+i]) begin
        sel_addr = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        rd_id    = IW'(i);
      end
    end
  end

  // Advance the ring pointer(s) past the winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_a <= '0;
      ptr_b <= '0;
    end else if (gnt_vld) begin
      if (PRIO_MODE == 0) begin
        ptr_a <= rr_next(gnt_idx, N);
      end else if (gnt_wr) begin
        ptr_a <= rr_next(gnt_idx, NUM_WR);
      end else begin
        ptr_b <= rr_next(gnt_idx - PW'(NUM_WR), NUM_RD);
      end
    end
  end

  // Register the winning request onto the RAM port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.ram_ena   <= 1'b0;
      bus.ram_write <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_din   <= '0;
    end else begin
      bus.ram_ena <= gnt_vld;
      if (gnt_vld) begin
        bus.ram_write <= gnt_wr;
        bus.ram_addr  <= sel_addr;
        if (gnt_wr) bus.ram_din <= sel_data;
      end
    end
  end

  // Track outstanding reads until their RAM data is due.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      for (int k = 0; k < D; k++) pid[k] <= '0;
    end else begin
      pv[0]  <= gnt_vld && !gnt_wr;
      pid[0] <= rd_id;
      for (int k = 1; k < D; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
      end
    end
  end

  // Steer the returning RAM word to its read port.
  always_comb begin
    bus.rd_rvalid = '0;
    bus.rd_rdata  = '0;
    if (pv[D-1]) begin
      bus.rd_rvalid = NUM_RD'(1) << pid[D-1];
      bus.rd_rdata  = bus.ram_dout;
    end
  end

endmodule
